// File: rtl/mpi_bb_noc_arbiter_pkg.sv
// Shared types and helpers for the Blackbone MPI NoC arbiter and its reusable picker.
package mpi_bb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  localparam int MAX_CHANNELS = 16;

  // A single channel still needs a 1-bit pointer so every port has a legal width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAX_PTR_W = ptr_width(MAX_CHANNELS);

endpackage

// File: rtl/mpi_bb_noc_arbiter_if.sv
// Flit-stream bundle between the send-buffer channels, the arbiter and the NoC link.
interface mpi_bb_noc_arbiter_if #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int N              = 2
);
  logic [N*NOC_FLIT_WIDTH-1:0] in_flit;
  logic [N-1:0]                in_last;
  logic [N-1:0]                in_valid;
  logic [N-1:0]                in_ready;
  logic [NOC_FLIT_WIDTH-1:0]   out_flit;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/mpi_bb_noc_arbiter_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module mpi_bb_rr_arb
  import mpi_bb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mpi_bb_noc_arbiter.sv
// Packet-granular round-robin merge of N flit streams onto one registered NoC link.
module mpi_bb_noc_arbiter
  import mpi_bb_pkg::*;
#(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int N              = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mpi_bb_noc_arbiter_if.slave  bus,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  localparam int PW = ptr_width(N);

  arb_state_t          state;
  logic [PW-1:0]       owner, ptr, arb_idx, sel_idx, nxt_ptr;
  logic [N-1:0]        arb_gnt, sel_gnt;
  logic                space, acc, acc_last;
  logic [NOC_FLIT_WIDTH-1:0] acc_flit;

  mpi_bb_rr_arb #(.N(N)) u_arb (
    .req (bus.in_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Once locked, other channels' requests are invisible until the owner's last flit.
  always_comb begin
    sel_gnt = arb_gnt;
    sel_idx = arb_idx;
    if (state == LOCKED) begin
      sel_gnt = N'(1) << owner;
      sel_idx = owner;
    end
  end

  assign space        = !bus.out_valid || bus.out_ready;
  assign grant        = rst ? sel_gnt : '0;
  assign bus.in_ready = space ? grant : '0;
  assign acc          = |(bus.in_ready & bus.in_valid);
  assign acc_flit     = bus.in_flit[int'(sel_idx)*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
  assign acc_last     = bus.in_last[sel_idx];
  assign nxt_ptr      = (int'(sel_idx) == N-1) ? '0 : sel_idx + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= '0;
      ptr           <= '0;
      busy          <= 1'b0;
      pkt_count     <= '0;
      bus.out_flit  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (acc) begin
      bus.out_flit  <= acc_flit;
      bus.out_last  <= acc_last;
      bus.out_valid <= 1'b1;
      if (acc_last) begin
        state     <= IDLE;
        busy      <= 1'b0;
        ptr       <= nxt_ptr;
        pkt_count <= pkt_count + CNT_WIDTH'(1);
      end else begin
        state <= LOCKED;
        busy  <= 1'b1;
        owner <= sel_idx;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mpi_bb_noc_arbiter.sv
// Randomized and directed check of the NoC arbiter against a packet-level round-robin model.
module tb_mpi_bb_noc_arbiter;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  grant;
  logic          busy;
  logic [CW-1:0] pkt_count;

  always #5 clk = ~clk;

  mpi_bb_noc_arbiter_if #(.NOC_FLIT_WIDTH(W), .N(N)) bus ();

  mpi_bb_noc_arbiter #(.NOC_FLIT_WIDTH(W), .N(N), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: who owns the link (-1 = nobody), rotating priority start, output slot.
  int           m_owner, m_ptr, m_cnt, m_acc;
  bit           m_ov, m_ol;
  logic [W-1:0] m_of;
  int           busy_seen;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_acc = -1;
    m_ov = 1'b0; m_ol = 1'b0; m_of = '0;
  endfunction

  task automatic drive(input int ch, input bit v, input logic [W-1:0] f, input bit l);
    bus.in_valid[ch]        = v;
    bus.in_flit[ch*W +: W]  = f;
    bus.in_last[ch]         = l;
  endtask

  // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic cycle();
    int           g, acc_ch;
    bit           sp, ordy, acc_last;
    logic [N-1:0] eg;
    logic [W-1:0] acc_flit;
    @(negedge clk);
    g = m_owner;
    for (int k = 0; k < N; k++)
      if (g < 0 && bus.in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    sp = !m_ov || bus.out_ready;
    chk("grant", grant, eg);
    chk("in_ready", bus.in_ready, sp ? eg : '0);
    acc_ch   = (g >= 0 && sp && bus.in_valid[g]) ? g : -1;
    acc_flit = '0;
    acc_last = 1'b0;
    if (acc_ch >= 0) begin
      acc_flit = bus.in_flit[acc_ch*W +: W];
      acc_last = bus.in_last[acc_ch];
    end
    ordy = bus.out_ready;
    @(posedge clk); #1;
    m_acc = acc_ch;
    if (acc_ch >= 0) begin
      m_ov = 1'b1; m_of = acc_flit; m_ol = acc_last;
      if (acc_last) begin
        m_owner = -1;
        m_ptr   = (acc_ch + 1) % N;
        m_cnt   = (m_cnt + 1) % (1 << CW);
      end else begin
        m_owner = acc_ch;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_flit", bus.out_flit, m_of);
    chk("out_last", bus.out_last, m_ol);
    chk("busy", busy, m_owner >= 0);
    chk("pkt_count", pkt_count, m_cnt);
    if (busy) busy_seen++;
  endtask

  task automatic send_pkt(input int ch, input logic [W-1:0] base, input int len);
    for (int k = 0; k < len; k++) begin
      int t;
      drive(ch, 1'b1, base + k, k == len - 1);
      t = 0;
      do begin
        cycle();
        t++;
      end while (m_acc != ch && t < 50);
      if (m_acc != ch) chk("send_timeout", 0, 1);
    end
    drive(ch, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid  = '1;
    bus.in_last   = '0;
    bus.in_flit   = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_grant", grant, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_flit", bus.out_flit, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_count", pkt_count, 0);
    bus.in_valid = '0;
    rst = 1'b1;
    model_reset();
  endtask

  bit           pend [N];
  logic [W-1:0] pf   [N];
  bit           pl   [N];
  int           acc_q[$];
  int           seq  [N];
  int           hold_stable;

  initial begin
    model_reset();
    do_reset();

    // 3-flit packet from channel 0
    busy_seen = 0;
    send_pkt(0, 32'hA0, 3);
    repeat (2) cycle();
    chk("t1_busy_cycles", busy_seen, 2);
    chk("t1_pkt_count", pkt_count, 1);

    // Both channels stream 2-flit packets; packets must alternate whole
    seq[0] = 0; seq[1] = 0;
    acc_q.delete();
    for (int c = 0; c < 8; c++) begin
      for (int ch = 0; ch < N; ch++) drive(ch, 1'b1, {ch[7:0], 24'(seq[ch])}, seq[ch][0]);
      cycle();
      if (m_acc >= 0) begin
        acc_q.push_back(m_acc);
        seq[m_acc]++;
      end
    end
    bus.in_valid = '0;
    chk("t2_accepts", acc_q.size(), 8);
    for (int k = 0; k < acc_q.size(); k++)
      chk("t2_alternate", acc_q[k], acc_q[0] ^ ((k / 2) % 2));
    cycle();

    // Channel 1 arrives mid-packet and must wait for channel 0's last flit
    drive(0, 1'b1, 32'hB0, 1'b0); cycle();
    drive(0, 1'b1, 32'hB1, 1'b0); drive(1, 1'b1, 32'hC0, 1'b1); cycle();
    chk("t3_ch1_blocked", bus.in_ready[1], 0);
    drive(0, 1'b1, 32'hB2, 1'b1); cycle();
    drive(0, 1'b0, '0, 1'b0); cycle();
    chk("t3_ch1_next", bus.out_flit, 32'hC0);
    drive(1, 1'b0, '0, 1'b0); cycle();

    // Output stall for 4 cycles
    drive(0, 1'b1, 32'hD0, 1'b1); cycle();
    bus.out_ready = 1'b0;
    drive(0, 1'b1, 32'hD1, 1'b1); drive(1, 1'b1, 32'hE0, 1'b1);
    hold_stable = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (bus.out_flit == 32'hD0 && bus.in_ready == '0) hold_stable++;
    end
    chk("t4_stall_hold", hold_stable, 4);
    bus.out_ready = 1'b1;
    cycle(); chk("t4_first_after", bus.out_flit, 32'hE0);
    drive(1, 1'b0, '0, 1'b0);
    cycle(); chk("t4_second_after", bus.out_flit, 32'hD1);
    drive(0, 1'b0, '0, 1'b0);
    cycle();

    // Randomized traffic with backpressure and owners that pause mid-packet
    for (int ch = 0; ch < N; ch++) pend[ch] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (!pend[ch] && $urandom_range(0, 1) == 1) begin
          pend[ch] = 1'b1;
          pf[ch]   = $urandom;
          pl[ch]   = ($urandom_range(0, 2) == 0);
        end
        drive(ch, pend[ch] && ($urandom_range(0, 3) != 0), pf[ch], pl[ch]);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (m_acc >= 0) pend[m_acc] = 1'b0;
    end
    // Flush any open packet so the next phase starts idle
    bus.out_ready = 1'b1;
    bus.in_valid  = '0;
    if (m_owner >= 0) begin
      drive(m_owner, 1'b1, 32'hF1F1, 1'b1);
      cycle();
      bus.in_valid = '0;
    end
    cycle();

    // Reset pulse while channel 1 holds the link
    drive(0, 1'b1, 32'h50, 1'b1);
    for (int c = 0; c < 3 && m_acc != 0; c++) cycle();
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b1, 32'h60, 1'b0); cycle();
    chk("t6_locked", busy, 1);
    rst = 1'b0;
    #1;
    chk("t6_async_valid", bus.out_valid, 0);
    chk("t6_async_flit", bus.out_flit, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_grant", grant, 0);
    chk("t6_async_ready", bus.in_ready, 0);
    chk("t6_async_cnt", pkt_count, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    drive(0, 1'b1, 32'h70, 1'b1); drive(1, 1'b1, 32'h61, 1'b1);
    cycle(); chk("t6_ptr_zero_win", bus.out_flit, 32'h70);
    drive(0, 1'b0, '0, 1'b0);
    cycle(); chk("t6_ch1_after", bus.out_flit, 32'h61);
    drive(1, 1'b0, '0, 1'b0);
    cycle();

    // Counter wrap: 17 single-flit packets on a 4-bit counter
    do_reset();
    for (int c = 0; c < 17; c++) begin
      drive(0, 1'b1, 32'(c), 1'b1);
      cycle();
    end
    drive(0, 1'b0, '0, 1'b0);
    cycle();
    chk("t5_wrap", pkt_count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
